riscv_opfetch: RTL and testbench
================================

RISCV_OPFETCH -- requirements
Module: riscv_opfetch

Interface
REQ-001 Parameter: XLEN, 32, data/PC width, taken from riscv_param.v.
REQ-002 Clock and reset SHALL be one clock with synchronous, active-high reset.
REQ-003 i_opfetch_clk  in  1  clock; all state updates on its rising edge.
REQ-004 i_opfetch_rst  in  1  synchronous active-high reset.
REQ-005 i_opfetch_in_valid  in  1  upstream decode presents an instruction.
REQ-006 o_opfetch_in_ready  out  1  stage accepts the input this cycle.
REQ-007 i_opfetch_pc  in  XLEN  PC of the input instruction.
REQ-008 i_opfetch_rs1_addr / i_opfetch_rs2_addr / i_opfetch_rd_addr  in  5 each  source and destination register indices.
REQ-009 o_opfetch_rs1_addr / o_opfetch_rs2_addr  out  5 each  combinational copies of the input indices, driven to the register file read ports.
REQ-010 i_opfetch_rs1_data / i_opfetch_rs2_data  in  XLEN each  asynchronous register file read data.
REQ-011 i_opfetch_wb_wen, i_opfetch_wb_addr[5], i_opfetch_wb_data[XLEN]  in  writeback port, identical to what the register file writes this cycle.
REQ-012 i_opfetch_flush  in  1  discard all in-flight and incoming instructions.
REQ-013 o_opfetch_out_valid  out  1; i_opfetch_out_ready  in  1  downstream (execute) handshake.
REQ-014 o_opfetch_pc[XLEN], o_opfetch_rs1_val[XLEN], o_opfetch_rs2_val[XLEN], o_opfetch_rd_addr[5]  out  registered payload.

Function
REQ-015 Transfer occurs on in_valid && in_ready (input) and on out_valid && out_ready (output); payload SHALL be stable while out_valid && !out_ready.
REQ-016 Latency SHALL be exactly one cycle: an instruction accepted at edge N is visible with out_valid=1 after edge N.
REQ-017 Operand capture: rsX_val = wb_data if wb_wen && wb_addr==rsX_addr && rsX_addr!=0; else 0 if rsX_addr==0; else rsX_data.
REQ-018 Held-operand snoop: while an entry is held (output or skid), a write with wb_wen && wb_addr==entry rsX_addr && addr!=0 SHALL replace that entry's rsX value at the same edge.
REQ-019 Writes to x0 SHALL never bypass or update any operand; x0 operands are always 0.
REQ-020 Without skid: in_ready = !out_valid || out_ready (combinational).
REQ-021 Simultaneous accept and output transfer SHALL load the new instruction with no bubble (full throughput).
REQ-022 Flush: at an edge with flush=1, out_valid and any skid entry SHALL clear; an input accepted in that cycle SHALL be discarded; in_ready is unaffected by flush.
REQ-023 Flush and reset have priority over accept, snoop and drain.

Reset
REQ-024 On rst=1 at an edge: out_valid=0, skid entry invalid, o_opfetch_pc=0, rs1_val=0, rs2_val=0, rd_addr=0.
REQ-025 Reset asserted mid-stall SHALL drop the held instruction; no output transfer follows.
REQ-026 During reset, in_ready SHALL be 0 (with skid) or follow REQ-020 with out_valid=0 (without skid); accepted inputs are discarded.

Configuration
REQ-027 Macro RISCV_OPFETCH_SKID_EN SHALL select a one-entry skid buffer.
REQ-028 With macro: in_ready = !skid_valid (registered, no combinational path from out_ready); an input accepted while out_valid && !out_ready goes to the skid entry; on the next output transfer the skid entry moves to the output; order preserved; skid entry applies REQ-017/018.
REQ-029 Without macro: no skid storage; REQ-020 applies.

Verification
REQ-030 Accept rs1=5 with regfile data 0x11 and wb writing x5=0xAA same cycle -> next cycle out_valid=1, rs1_val=0xAA.
REQ-031 rs1=0, rs2=0 with wb_wen, wb_addr=0, wb_data=0xFF -> rs1_val=0, rs2_val=0.
REQ-032 Hold out_ready=0 three cycles with rs2=7 held; wb writes x7=0x1234 in cycle 2 -> rs2_val=0x1234 from cycle 3; pc unchanged.
REQ-033 Back-to-back stream of 8 instructions with out_ready=1 -> 8 outputs on consecutive cycles, in order, no bubble.
REQ-034 Flush while stalled and in_valid=1 -> next cycle out_valid=0; discarded instruction never appears.
REQ-035 With RISCV_OPFETCH_SKID_EN: out_ready=0, two inputs A,B accepted -> in_ready=0 next cycle; release out_ready -> A then B, then in_ready=1.

Source files
------------

// File: rtl/riscv_opfetch.sv
// riscv_opfetch -- operand fetch stage between decode and execute.
//
// Purpose:
//    Accepts one decoded instruction per cycle and reads its source
//    operands from the register file. The writeback port is forwarded
//    into both the freshly captured operands and any operands still
//    waiting in the stage. The result is registered, with one cycle of
//    latency and a valid/ready handshake on each side.
//
// Configuration macro:
//    RISCV_OPFETCH_SKID_EN - adds a one-entry skid buffer. With it,
//    in_ready becomes a registered signal that no longer depends on
//    out_ready. Without it (the default), in_ready = !out_valid || out_ready.
//
// Ports:
//    i_opfetch_clk, i_opfetch_rst          clock, synchronous active-high reset
//    i_opfetch_in_valid / o_opfetch_in_ready  upstream handshake
//    i_opfetch_pc, i_opfetch_rs1/rs2/rd_addr  incoming instruction fields
//    o_opfetch_rs1_addr / o_opfetch_rs2_addr  register file read addresses
//    i_opfetch_rs1_data / i_opfetch_rs2_data  register file read data
//    i_opfetch_wb_wen/_addr/_data            writeback port (forwarding source)
//    i_opfetch_flush                         drop held and incoming instructions
//    o_opfetch_out_valid / i_opfetch_out_ready downstream handshake
//    o_opfetch_pc, _rs1_val, _rs2_val, _rd_addr registered payload
module riscv_opfetch #(
   parameter int XLEN = 32
) (
   input  logic            i_opfetch_clk,
   input  logic            i_opfetch_rst,
   input  logic            i_opfetch_in_valid,
   output logic            o_opfetch_in_ready,
   input  logic [XLEN-1:0] i_opfetch_pc,
   input  logic [4:0]      i_opfetch_rs1_addr,
   input  logic [4:0]      i_opfetch_rs2_addr,
   input  logic [4:0]      i_opfetch_rd_addr,
   output logic [4:0]      o_opfetch_rs1_addr,
   output logic [4:0]      o_opfetch_rs2_addr,
   input  logic [XLEN-1:0] i_opfetch_rs1_data,
   input  logic [XLEN-1:0] i_opfetch_rs2_data,
   input  logic            i_opfetch_wb_wen,
   input  logic [4:0]      i_opfetch_wb_addr,
   input  logic [XLEN-1:0] i_opfetch_wb_data,
   input  logic            i_opfetch_flush,
   output logic            o_opfetch_out_valid,
   input  logic            i_opfetch_out_ready,
   output logic [XLEN-1:0] o_opfetch_pc,
   output logic [XLEN-1:0] o_opfetch_rs1_val,
   output logic [XLEN-1:0] o_opfetch_rs2_val,
   output logic [4:0]      o_opfetch_rd_addr
);

   // Replaces an operand value with the writeback data when the writeback
   // targets that operand's register. x0 is never forwarded.
   function automatic logic [XLEN-1:0] snoopOp(input logic [4:0] addr,
                                               input logic [XLEN-1:0] held,
                                               input logic wen,
                                               input logic [4:0] wAddr,
                                               input logic [XLEN-1:0] wData);
      if (wen && (wAddr == addr) && (addr != 5'd0)) return wData;
      return held;
   endfunction

   logic            outValid_q, outValid_d;
   logic [XLEN-1:0] outPc_q, outPc_d;
   logic [XLEN-1:0] outRs1_q, outRs1_d;
   logic [XLEN-1:0] outRs2_q, outRs2_d;
   logic [4:0]      outRd_q, outRd_d;
   logic [4:0]      outRs1Addr_q, outRs1Addr_d;
   logic [4:0]      outRs2Addr_q, outRs2Addr_d;

   logic            inReady;
   logic            accept;
   logic            outFree;
   logic [XLEN-1:0] newRs1;
   logic [XLEN-1:0] newRs2;

   assign o_opfetch_rs1_addr = i_opfetch_rs1_addr;
   assign o_opfetch_rs2_addr = i_opfetch_rs2_addr;

   // x0 reads as zero no matter what the register file returns.
   // Otherwise a same-cycle writeback to the register wins over the
   // stale read data.
   assign newRs1 = snoopOp(i_opfetch_rs1_addr,
                           (i_opfetch_rs1_addr == 5'd0) ? '0 : i_opfetch_rs1_data,
                           i_opfetch_wb_wen, i_opfetch_wb_addr, i_opfetch_wb_data);
   assign newRs2 = snoopOp(i_opfetch_rs2_addr,
                           (i_opfetch_rs2_addr == 5'd0) ? '0 : i_opfetch_rs2_data,
                           i_opfetch_wb_wen, i_opfetch_wb_addr, i_opfetch_wb_data);

   // The output register can take a new entry this edge when it is empty
   // or when its current entry is leaving.
   assign outFree = !outValid_q || i_opfetch_out_ready;
   assign accept  = i_opfetch_in_valid && inReady;

`ifdef RISCV_OPFETCH_SKID_EN
   logic            skidValid_q, skidValid_d;
   logic [XLEN-1:0] skidPc_q, skidPc_d;
   logic [XLEN-1:0] skidRs1_q, skidRs1_d;
   logic [XLEN-1:0] skidRs2_q, skidRs2_d;
   logic [4:0]      skidRd_q, skidRd_d;
   logic [4:0]      skidRs1Addr_q, skidRs1Addr_d;
   logic [4:0]      skidRs2Addr_q, skidRs2Addr_d;

   // Ready depends only on registered state, which removes the
   // combinational path from out_ready. Ready is held low during reset.
   assign inReady = !skidValid_q && !i_opfetch_rst;
`else
   assign inReady = outFree;
`endif

   assign o_opfetch_in_ready = inReady;

   // Next-state logic. By default, every held entry keeps its contents
   // with the writeback snooped in. Flush drops everything. Otherwise the
   // output is refilled from the skid entry first, then from the input,
   // which keeps instructions in order.
   always_comb begin
      outValid_d   = outValid_q;
      outPc_d      = outPc_q;
      outRd_d      = outRd_q;
      outRs1Addr_d = outRs1Addr_q;
      outRs2Addr_d = outRs2Addr_q;
      outRs1_d     = snoopOp(outRs1Addr_q, outRs1_q, i_opfetch_wb_wen,
                             i_opfetch_wb_addr, i_opfetch_wb_data);
      outRs2_d     = snoopOp(outRs2Addr_q, outRs2_q, i_opfetch_wb_wen,
                             i_opfetch_wb_addr, i_opfetch_wb_data);
`ifdef RISCV_OPFETCH_SKID_EN
      skidValid_d   = skidValid_q;
      skidPc_d      = skidPc_q;
      skidRd_d      = skidRd_q;
      skidRs1Addr_d = skidRs1Addr_q;
      skidRs2Addr_d = skidRs2Addr_q;
      skidRs1_d     = snoopOp(skidRs1Addr_q, skidRs1_q, i_opfetch_wb_wen,
                              i_opfetch_wb_addr, i_opfetch_wb_data);
      skidRs2_d     = snoopOp(skidRs2Addr_q, skidRs2_q, i_opfetch_wb_wen,
                              i_opfetch_wb_addr, i_opfetch_wb_data);

      if (i_opfetch_flush) begin
         outValid_d  = 1'b0;
         skidValid_d = 1'b0;
      end else if (outFree) begin
         if (skidValid_q) begin
            outValid_d   = 1'b1;
            outPc_d      = skidPc_q;
            outRd_d      = skidRd_q;
            outRs1Addr_d = skidRs1Addr_q;
            outRs2Addr_d = skidRs2Addr_q;
            outRs1_d     = skidRs1_d;
            outRs2_d     = skidRs2_d;
            skidValid_d  = 1'b0;
         end else if (accept) begin
            outValid_d   = 1'b1;
            outPc_d      = i_opfetch_pc;
            outRd_d      = i_opfetch_rd_addr;
            outRs1Addr_d = i_opfetch_rs1_addr;
            outRs2Addr_d = i_opfetch_rs2_addr;
            outRs1_d     = newRs1;
            outRs2_d     = newRs2;
         end else begin
            outValid_d = 1'b0;
         end
      end else if (accept) begin
         skidValid_d   = 1'b1;
         skidPc_d      = i_opfetch_pc;
         skidRd_d      = i_opfetch_rd_addr;
         skidRs1Addr_d = i_opfetch_rs1_addr;
         skidRs2Addr_d = i_opfetch_rs2_addr;
         skidRs1_d     = newRs1;
         skidRs2_d     = newRs2;
      end
`else
      if (i_opfetch_flush) begin
         outValid_d = 1'b0;
      end else if (accept) begin
         outValid_d   = 1'b1;
         outPc_d      = i_opfetch_pc;
         outRd_d      = i_opfetch_rd_addr;
         outRs1Addr_d = i_opfetch_rs1_addr;
         outRs2Addr_d = i_opfetch_rs2_addr;
         outRs1_d     = newRs1;
         outRs2_d     = newRs2;
      end else if (outFree) begin
         outValid_d = 1'b0;
      end
`endif
   end

   // State registers. Reset clears the payload as well as the valid bits,
   // so the outputs read as zero after reset.
   always_ff @(posedge i_opfetch_clk) begin
      if (i_opfetch_rst) begin
         outValid_q    <= 1'b0;
         outPc_q       <= '0;
         outRs1_q      <= '0;
         outRs2_q      <= '0;
         outRd_q       <= '0;
         outRs1Addr_q  <= '0;
         outRs2Addr_q  <= '0;
`ifdef RISCV_OPFETCH_SKID_EN
         skidValid_q   <= 1'b0;
         skidPc_q      <= '0;
         skidRs1_q     <= '0;
         skidRs2_q     <= '0;
         skidRd_q      <= '0;
         skidRs1Addr_q <= '0;
         skidRs2Addr_q <= '0;
`endif
      end else begin
         outValid_q    <= outValid_d;
         outPc_q       <= outPc_d;
         outRs1_q      <= outRs1_d;
         outRs2_q      <= outRs2_d;
         outRd_q       <= outRd_d;
         outRs1Addr_q  <= outRs1Addr_d;
         outRs2Addr_q  <= outRs2Addr_d;
`ifdef RISCV_OPFETCH_SKID_EN
         skidValid_q   <= skidValid_d;
         skidPc_q      <= skidPc_d;
         skidRs1_q     <= skidRs1_d;
         skidRs2_q     <= skidRs2_d;
         skidRd_q      <= skidRd_d;
         skidRs1Addr_q <= skidRs1Addr_d;
         skidRs2Addr_q <= skidRs2Addr_d;
`endif
      end
   end

   assign o_opfetch_out_valid = outValid_q;
   assign o_opfetch_pc        = outPc_q;
   assign o_opfetch_rs1_val   = outRs1_q;
   assign o_opfetch_rs2_val   = outRs2_q;
   assign o_opfetch_rd_addr   = outRd_q;

endmodule

// File: tb/tb_riscv_opfetch.sv
// tb_riscv_opfetch -- directed testbench for riscv_opfetch.
// Tracks the instructions held in the stage with a scoreboard queue,
// together with a small register file model.
module tb_riscv_opfetch;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [4:0]  a1;
      logic [4:0]  a2;
   } entry_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        inValid, inReady;
   logic [31:0] pcIn;
   logic [4:0]  rs1A, rs2A, rdA;
   logic [4:0]  rs1AOut, rs2AOut;
   logic [31:0] rs1Data, rs2Data;
   logic        wbWen;
   logic [4:0]  wbAddr;
   logic [31:0] wbData;
   logic        flush;
   logic        outValid, outReady;
   logic [31:0] outPc, outRs1, outRs2;
   logic [4:0]  outRd;

   logic [31:0] regFile [32];
   entry_t      sb[$];
   int          total = 0;
   int          bad = 0;
   int          outCount = 0;
   bit          checking = 0;

   always #5 clock = ~clock;

   assign rs1Data = regFile[rs1A];
   assign rs2Data = regFile[rs2A];

   riscv_opfetch #(.XLEN(32)) dut (
      .i_opfetch_clk      (clock),
      .i_opfetch_rst      (reset),
      .i_opfetch_in_valid (inValid),
      .o_opfetch_in_ready (inReady),
      .i_opfetch_pc       (pcIn),
      .i_opfetch_rs1_addr (rs1A),
      .i_opfetch_rs2_addr (rs2A),
      .i_opfetch_rd_addr  (rdA),
      .o_opfetch_rs1_addr (rs1AOut),
      .o_opfetch_rs2_addr (rs2AOut),
      .i_opfetch_rs1_data (rs1Data),
      .i_opfetch_rs2_data (rs2Data),
      .i_opfetch_wb_wen   (wbWen),
      .i_opfetch_wb_addr  (wbAddr),
      .i_opfetch_wb_data  (wbData),
      .i_opfetch_flush    (flush),
      .o_opfetch_out_valid(outValid),
      .i_opfetch_out_ready(outReady),
      .o_opfetch_pc       (outPc),
      .o_opfetch_rs1_val  (outRs1),
      .o_opfetch_rs2_val  (outRs2),
      .o_opfetch_rd_addr  (outRd)
   );

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Operand value the stage should capture for a register index this cycle.
   function automatic logic [31:0] expOperand(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wbWen && wbAddr == a) return wbData;
      return regFile[a];
   endfunction

   // Runs one clock cycle. The checks happen mid-cycle, at the falling
   // edge. At the rising edge the model retires, snoops and pushes entries,
   // then the register file takes the writeback.
   task automatic applyStimulus();
      logic   acc, xfer, expReady;
      entry_t e;
      #4;
      if (checking) begin
`ifdef RISCV_OPFETCH_SKID_EN
         expReady = (sb.size() < 2) && !reset;
`else
         expReady = (sb.size() == 0) || outReady;
`endif
         checkOutput("in_ready", {31'd0, inReady}, {31'd0, expReady});
         checkOutput("out_valid", {31'd0, outValid}, {31'd0, sb.size() != 0});
         checkOutput("rs_addr_route", {22'd0, rs1AOut, rs2AOut}, {22'd0, rs1A, rs2A});
         if (sb.size() != 0) begin
            checkOutput("out_pc", outPc, sb[0].pc);
            checkOutput("out_rs1", outRs1, sb[0].rs1);
            checkOutput("out_rs2", outRs2, sb[0].rs2);
            checkOutput("out_rd", {27'd0, outRd}, {27'd0, sb[0].rd});
         end
      end
      acc  = inValid && inReady;
      xfer = outValid && outReady;
      e.pc = pcIn; e.rd = rdA; e.a1 = rs1A; e.a2 = rs2A;
      e.rs1 = expOperand(rs1A);
      e.rs2 = expOperand(rs2A);
      @(posedge clock);
      if (reset || flush) begin
         sb.delete();
      end else begin
         if (xfer) begin
            void'(sb.pop_front());
            outCount++;
         end
         foreach (sb[i]) begin
            if (wbWen && wbAddr != 5'd0 && wbAddr == sb[i].a1) sb[i].rs1 = wbData;
            if (wbWen && wbAddr != 5'd0 && wbAddr == sb[i].a2) sb[i].rs2 = wbData;
         end
         if (acc) sb.push_back(e);
      end
      if (wbWen && wbAddr != 5'd0) regFile[wbAddr] = wbData;
      #1;
   endtask

   task automatic setIn(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd);
      inValid = 1'b1; pcIn = pc; rs1A = a1; rs2A = a2; rdA = rd;
   endtask

   task automatic setWb(input logic wen, input logic [4:0] a, input logic [31:0] d);
      wbWen = wen; wbAddr = a; wbData = d;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regFile[i] = 32'h100 + 32'(i) * 3;
      regFile[0] = 32'hDEAD_BEEF;
      regFile[5] = 32'h11;
      regFile[7] = 32'h77;
      reset = 1'b1; inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
      pcIn = '0; rs1A = '0; rs2A = '0; rdA = '0;
      setWb(1'b0, 5'd0, 32'd0);

      // Reset values
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      checkOutput("rst_valid", {31'd0, outValid}, 32'd0);
      checkOutput("rst_pc", outPc, 32'd0);
      checkOutput("rst_rs1", outRs1, 32'd0);
      checkOutput("rst_rs2", outRs2, 32'd0);
      checkOutput("rst_rd", {27'd0, outRd}, 32'd0);
      checking = 1;

      // Same-cycle writeback bypass into rs1
      outReady = 1'b1;
      setIn(32'h100, 5'd5, 5'd6, 5'd1);
      setWb(1'b1, 5'd5, 32'hAA);
      applyStimulus();
      inValid = 1'b0; setWb(1'b0, 5'd0, 32'd0);
      checkOutput("bypass_valid", {31'd0, outValid}, 32'd1);
      checkOutput("bypass_rs1", outRs1, 32'hAA);

      // x0 operands ignore a writeback to x0
      setIn(32'h104, 5'd0, 5'd0, 5'd2);
      setWb(1'b1, 5'd0, 32'hFF);
      applyStimulus();
      inValid = 1'b0; setWb(1'b0, 5'd0, 32'd0);
      checkOutput("x0_rs1", outRs1, 32'd0);
      checkOutput("x0_rs2", outRs2, 32'd0);
      applyStimulus();

      // Stall with snoop of a held operand
      outReady = 1'b0;
      setIn(32'h200, 5'd3, 5'd7, 5'd9);
      applyStimulus();
      inValid = 1'b0;
      applyStimulus();
      setWb(1'b1, 5'd7, 32'h1234);
      applyStimulus();
      setWb(1'b0, 5'd0, 32'd0);
      checkOutput("snoop_rs2", outRs2, 32'h1234);
      checkOutput("snoop_pc", outPc, 32'h200);
      applyStimulus();
      outReady = 1'b1;
      applyStimulus();

      // Back-to-back stream of eight instructions
      outCount = 0;
      for (int i = 0; i < 8; i++) begin
         setIn(32'h300 + 32'(i) * 4, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'(i + 1));
         setWb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         applyStimulus();
      end
      inValid = 1'b0; setWb(1'b0, 5'd0, 32'd0);
      applyStimulus();
      checkOutput("stream_count", 32'(outCount), 32'd8);

      // Flush while stalled, with a new input presented
      outReady = 1'b0;
      setIn(32'h400, 5'd1, 5'd2, 5'd3);
      applyStimulus();
      setIn(32'h500, 5'd4, 5'd5, 5'd6);
      flush = 1'b1;
      applyStimulus();
      flush = 1'b0; inValid = 1'b0;
      checkOutput("flush_valid", {31'd0, outValid}, 32'd0);
      outReady = 1'b1;
      applyStimulus();
      applyStimulus();

      // Reset in the middle of a stall
      outReady = 1'b0;
      setIn(32'h600, 5'd8, 5'd9, 5'd10);
      applyStimulus();
      reset = 1'b1;
      setIn(32'h700, 5'd11, 5'd12, 5'd13);
      applyStimulus();
      reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
      checkOutput("mrst_valid", {31'd0, outValid}, 32'd0);
      checkOutput("mrst_pc", outPc, 32'd0);
      checkOutput("mrst_rs1", outRs1, 32'd0);
      checkOutput("mrst_rd", {27'd0, outRd}, 32'd0);
      applyStimulus();
      applyStimulus();

`ifdef RISCV_OPFETCH_SKID_EN
      // Skid buffer: two inputs accepted while output is stalled
      outReady = 1'b0;
      setIn(32'h800, 5'd5, 5'd7, 5'd1);
      applyStimulus();
      setIn(32'h804, 5'd3, 5'd0, 5'd2);
      applyStimulus();
      inValid = 1'b0;
      checkOutput("skid_ready", {31'd0, inReady}, 32'd0);
      checkOutput("skid_head_pc", outPc, 32'h800);
      setWb(1'b1, 5'd3, 32'h55);
      applyStimulus();
      setWb(1'b0, 5'd0, 32'd0);
      outReady = 1'b1;
      applyStimulus();
      checkOutput("skid_second_pc", outPc, 32'h804);
      checkOutput("skid_second_rs1", outRs1, 32'h55);
      checkOutput("skid_ready_back", {31'd0, inReady}, 32'd1);
      applyStimulus();
      applyStimulus();
`endif

      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
